// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the d16 UART receiver
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK
  } rx_state_t;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_LEVEL  = 2'd2;
  localparam logic [1:0] ADDR_CTRL   = 2'd3;

  localparam int STAT_NE   = 0;
  localparam int STAT_FULL = 1;
  localparam int STAT_OV   = 2;
  localparam int STAT_FE   = 3;
  localparam int STAT_PE   = 4;
  localparam int STAT_IE   = 5;

  localparam int         OVERSAMPLE = 16;
  localparam logic [3:0] VOTE_A     = 4'd7;
  localparam logic [3:0] VOTE_B     = 4'd8;
  localparam logic [3:0] VOTE_C     = 4'd9;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// rtl/uart_rx_fifo_if.sv - d16 register bus bundle for the UART receiver
interface uart_rx_fifo_if;
  logic [1:0] i_addr;
  logic [7:0] i_dat;
  logic [7:0] o_dat;
  logic       i_we;
  logic       i_cyc;

  modport master (output i_addr, i_dat, i_we, i_cyc, input o_dat);
  modport slave  (input i_addr, i_dat, i_we, i_cyc, output o_dat);
endinterface

// File: rtl/uart_fifo.sv
// rtl/uart_fifo.sv - synchronous FIFO; push on full is accepted when a pop happens in the same cycle
module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     i_clk,
  input  logic                     i_reset_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             push_ok, pop_ok;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      if (push_ok && !pop_ok)      count <= count + 1'b1;
      else if (pop_ok && !push_ok) count <= count - 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - 16x oversampled UART receiver with FIFO and interrupt; UART_RX_PARITY_EN adds a parity bit
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int SYS_CLK    = 50_000_000,
  parameter int BAUDRATE   = 115200,
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int INT_LEVEL  = 1
`ifdef UART_RX_PARITY_EN
  ,
  parameter bit PARITY_ODD = 1'b0
`endif
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  uart_rx_fifo_if.slave bus,
  input  logic          rx,
  output logic          o_int
);
  localparam int OSDIV = SYS_CLK / (BAUDRATE * OVERSAMPLE);
  localparam int OSW   = $clog2(OSDIV);
  localparam int SCW   = $clog2(OVERSAMPLE);
  localparam int CW    = $clog2(FIFO_DEPTH) + 1;
  localparam logic [OSW-1:0] OS_RELOAD = OSW'(OSDIV - 1);
  localparam logic [2:0]     LAST_BIT  = 3'(DATA_BITS - 1);
  localparam logic [CW-1:0]  INT_THR   = CW'(INT_LEVEL);
`ifdef UART_RX_PARITY_EN
  localparam rx_state_t AFTER_DATA = ST_PARITY;
`else
  localparam rx_state_t AFTER_DATA = ST_STOP;
`endif

  rx_state_t            state_q, state_d;
  logic                 rx_meta, rx_s, rx_s_d;
  logic [OSW-1:0]       os_cnt;
  logic [SCW-1:0]       sc;
  logic                 tick, decide, vote, v_a, v_b;
  logic [2:0]           bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 restart, shift_en, push_req, fe_set, pe_set;
  logic                 push_q, ov_q, fe_q, pe_q, ie_q, int_q;
  logic                 rd, wr, pop_req, stat_rd, ov_set;
  logic [DATA_BITS-1:0] fifo_rdata;
  logic                 fifo_full, fifo_empty;
  logic [CW-1:0]        fifo_count;
  logic [8:0]           cnt_ext;
  logic [7:0]           rd_word, status;
  logic                 unused_dat;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) {rx_meta, rx_s, rx_s_d} <= 3'b111;
    else            {rx_meta, rx_s, rx_s_d} <= {rx, rx_meta, rx_s};
  end

  assign tick   = (os_cnt == '0);
  assign decide = tick && (sc == VOTE_C);
  assign vote   = majority3(v_a, v_b, rx_s);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      os_cnt <= OS_RELOAD;
      sc     <= '0;
      v_a    <= 1'b1;
      v_b    <= 1'b1;
    end else begin
      if (restart) begin
        os_cnt <= OS_RELOAD;
        sc     <= '0;
      end else if (tick) begin
        os_cnt <= OS_RELOAD;
        sc     <= sc + 1'b1;
      end else begin
        os_cnt <= os_cnt - 1'b1;
      end
      if (tick && sc == VOTE_A) v_a <= rx_s;
      if (tick && sc == VOTE_B) v_b <= rx_s;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) state_q <= ST_IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    restart  = 1'b0;
    shift_en = 1'b0;
    push_req = 1'b0;
    fe_set   = 1'b0;
    pe_set   = 1'b0;
    case (state_q)
      ST_IDLE: if (rx_s_d && !rx_s) begin
        state_d = ST_START;
        restart = 1'b1;
      end
      ST_START: if (decide) state_d = vote ? ST_IDLE : ST_DATA;
      ST_DATA: if (decide) begin
        shift_en = 1'b1;
        if (bit_cnt == LAST_BIT) state_d = AFTER_DATA;
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: if (decide) begin
        pe_set  = ((^shreg) ^ vote) != PARITY_ODD;
        state_d = ST_STOP;
      end
`endif
      ST_STOP: if (decide) begin
        if (vote) begin
          push_req = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          fe_set  = 1'b1;
          state_d = ST_BREAK;
        end
      end
      // a held-low line must return high before another start can be seen
      ST_BREAK: if (rx_s) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign rd      = bus.i_cyc && !bus.i_we;
  assign wr      = bus.i_cyc && bus.i_we;
  assign pop_req = rd && (bus.i_addr == ADDR_DATA);
  assign stat_rd = rd && (bus.i_addr == ADDR_STATUS);
  assign ov_set  = push_q && fifo_full && !pop_req;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      bit_cnt <= '0;
      shreg   <= '0;
      push_q  <= 1'b0;
      ov_q    <= 1'b0;
      fe_q    <= 1'b0;
      pe_q    <= 1'b0;
      ie_q    <= 1'b0;
      int_q   <= 1'b0;
    end else begin
      if (restart)       bit_cnt <= '0;
      else if (shift_en) bit_cnt <= bit_cnt + 1'b1;
      if (shift_en) shreg <= {vote, shreg[DATA_BITS-1:1]};
      push_q <= push_req;
      // a flag raised in the same cycle as a status read survives the clear
      ov_q <= (ov_q && !stat_rd) || ov_set;
      fe_q <= (fe_q && !stat_rd) || fe_set;
      pe_q <= (pe_q && !stat_rd) || pe_set;
      if (wr && bus.i_addr == ADDR_CTRL) ie_q <= bus.i_dat[0];
      int_q <= ie_q && (fifo_count >= INT_THR);
    end
  end

  uart_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .push      (push_q),
    .wdata     (shreg),
    .pop       (pop_req),
    .rdata     (fifo_rdata),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_comb begin
    rd_word                  = '0;
    rd_word[DATA_BITS-1:0]   = fifo_rdata;
    status                   = '0;
    status[STAT_NE]          = !fifo_empty;
    status[STAT_FULL]        = fifo_full;
    status[STAT_OV]          = ov_q;
    status[STAT_FE]          = fe_q;
    status[STAT_PE]          = pe_q;
    status[STAT_IE]          = ie_q;
    cnt_ext                  = 9'(fifo_count);
    bus.o_dat                = '0;
    case (bus.i_addr)
      ADDR_DATA:   bus.o_dat = fifo_empty ? 8'h00 : rd_word;
      ADDR_STATUS: bus.o_dat = status;
      ADDR_LEVEL:  bus.o_dat = cnt_ext[8] ? 8'hFF : cnt_ext[7:0];
      default:     bus.o_dat = {7'b0, ie_q};
    endcase
  end

  assign unused_dat = ^bus.i_dat[7:1];
  assign o_int      = int_q;

endmodule
